// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/trap sequencer: FSM states,
// trap cause codes and the default trap vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    TRAP      = 2'd1,
    MRET_WAIT = 2'd2
  } ctrl_state_e;

  localparam int unsigned CAUSE_ILLEGAL  = 32'd2;
  localparam int unsigned CAUSE_MISALIGN = 32'd4;
  localparam int unsigned CAUSE_EXT_IRQ  = 32'd11;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_1000;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
// Purely combinational so the forwarding unit can share it.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  output logic       hazard_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency
  assign rs1_hit_s = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit_s = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign hazard_o  = ex_valid_i && ex_load_i && (ex_rd_i != 5'd0) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect/trap sequencer for the 5-stage pipeline.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR,
  parameter int unsigned CAUSE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_pc,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_illegal,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic [4:0]         ex_rd,
  input  logic               ex_load,
  input  logic               ex_redirect,
  input  logic [31:0]        ex_target,
  input  logic               ex_misalign,
  input  logic               ex_mret,
  input  logic               irq,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               ifid_flush,
  output logic               idex_stall,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               csr_we,
  output logic [31:0]        mepc_wdata,
  output logic [CAUSE_W-1:0] mcause_wdata,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
  output logic [15:0]        trap_cnt,
`endif
  output logic               in_trap
);

  ctrl_state_e state_q, state_d;
  logic        in_trap_q, in_trap_d;
  logic [31:0] epc_cap_q, epc_cap_d;
  logic [31:0] mepc_q, mepc_d;

  logic               load_use_s;
  logic               stall_s;
  logic               ifid_flush_s;
  logic               idex_flush_s;
  logic               exmem_flush_s;
  logic               redirect_s;
  logic [31:0]        redirect_pc_s;
  logic               csr_we_s;
  logic [31:0]        mepc_wdata_s;
  logic [CAUSE_W-1:0] mcause_wdata_s;

  load_use_detect u_load_use (
    .ex_valid_i   (ex_valid),
    .ex_load_i    (ex_load),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .hazard_o     (load_use_s)
  );

  // Next-state and stage control; at most one RUN event fires, so stall and flush never overlap
  always_comb begin
    state_d        = state_q;
    in_trap_d      = in_trap_q;
    epc_cap_d      = epc_cap_q;
    mepc_d         = mepc_q;
    stall_s        = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    exmem_flush_s  = 1'b0;
    redirect_s     = 1'b0;
    redirect_pc_s  = 32'h0000_0000;
    csr_we_s       = 1'b0;
    mepc_wdata_s   = 32'h0000_0000;
    mcause_wdata_s = '0;
    case (state_q)
      RUN: begin
        if (ex_valid && ex_misalign) begin
          csr_we_s       = 1'b1;
          mepc_wdata_s   = ex_pc;
          mcause_wdata_s = CAUSE_W'(CAUSE_MISALIGN);
          exmem_flush_s  = 1'b1;
          idex_flush_s   = 1'b1;
          ifid_flush_s   = 1'b1;
          state_d        = TRAP;
        end else if (ex_valid && ex_mret) begin
          redirect_s    = 1'b1;
          redirect_pc_s = mepc_q;
          idex_flush_s  = 1'b1;
          ifid_flush_s  = 1'b1;
          state_d       = MRET_WAIT;
        end else if (ex_valid && ex_redirect) begin
          redirect_s    = 1'b1;
          redirect_pc_s = ex_target;
          idex_flush_s  = 1'b1;
          ifid_flush_s  = 1'b1;
        end else if (id_valid && id_illegal) begin
          csr_we_s       = 1'b1;
          mepc_wdata_s   = id_pc;
          mcause_wdata_s = CAUSE_W'(CAUSE_ILLEGAL);
          idex_flush_s   = 1'b1;
          ifid_flush_s   = 1'b1;
          state_d        = TRAP;
        end else if (irq && !in_trap_q && id_valid) begin
          // the EX instruction retires; the ID instruction is the resume point
          csr_we_s       = 1'b1;
          mepc_wdata_s   = id_pc;
          mcause_wdata_s = CAUSE_W'(CAUSE_EXT_IRQ);
          idex_flush_s   = 1'b1;
          ifid_flush_s   = 1'b1;
          state_d        = TRAP;
        end else if (load_use_s) begin
          stall_s = 1'b1;
        end else begin
          state_d = RUN;
        end
        if (csr_we_s) begin
          epc_cap_d = mepc_wdata_s;
        end else begin
          epc_cap_d = epc_cap_q;
        end
      end
      TRAP: begin
        redirect_s    = 1'b1;
        redirect_pc_s = TRAP_VECTOR;
        idex_flush_s  = 1'b1;
        ifid_flush_s  = 1'b1;
        in_trap_d     = 1'b1;
        mepc_d        = epc_cap_q;
        state_d       = RUN;
      end
      MRET_WAIT: begin
        ifid_flush_s = 1'b1;
        in_trap_d    = 1'b0;
        state_d      = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Sequencer state, trap-mode flag and exception PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      in_trap_q <= 1'b0;
      epc_cap_q <= 32'h0000_0000;
      mepc_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      in_trap_q <= in_trap_d;
      epc_cap_q <= epc_cap_d;
      mepc_q    <= mepc_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, whatever the inputs do
  assign pc_stall     = rst_n & stall_s;
  assign ifid_stall   = rst_n & stall_s;
  assign idex_stall   = rst_n & stall_s;
  assign ifid_flush   = rst_n & ifid_flush_s;
  assign idex_flush   = rst_n & idex_flush_s;
  assign exmem_flush  = rst_n & exmem_flush_s;
  assign redirect     = rst_n & redirect_s;
  assign redirect_pc  = {32{rst_n}} & redirect_pc_s;
  assign csr_we       = rst_n & csr_we_s;
  assign mepc_wdata   = {32{rst_n}} & mepc_wdata_s;
  assign mcause_wdata = {CAUSE_W{rst_n}} & mcause_wdata_s;
  assign in_trap      = in_trap_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [15:0] trap_cnt_q;

  // Saturating event counters; a TRAP-state cycle marks exactly one trap entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      trap_cnt_q  <= 16'd0;
    end else begin
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((ifid_flush_s || idex_flush_s || exmem_flush_s) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if ((state_q == TRAP) && (trap_cnt_q != 16'hFFFF)) begin
        trap_cnt_q <= trap_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign trap_cnt  = trap_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
- Detects load-use hazards and EX-stage control-flow changes.
- Detects synchronous exceptions, external interrupts and MRET.
- Drives per-stage stall/flush, PC redirect, and trap CSR capture.
- Sits beside the hazard-free datapath; the pipeline registers consume its stall/flush outputs directly.

Parameters:
TRAP_VECTOR, 32'h0000_1000, PC loaded on trap entry
CAUSE_W, 4, width of cause code

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  32  PC of instruction in ID
id_rs1  in  5  ID source 1
id_rs2  in  5  ID source 2
id_use_rs1  in  1  ID reads rs1
id_use_rs2  in  1  ID reads rs2
id_illegal  in  1  ID decode found illegal opcode
ex_valid  in  1  EX holds a real instruction
ex_pc  in  32  PC of instruction in EX
ex_rd  in  5  EX destination
ex_load  in  1  EX instruction is a load (MemRead)
ex_redirect  in  1  EX branch taken, jal or jalr
ex_target  in  32  EX computed target
ex_misalign  in  1  EX load/store address misaligned
ex_mret  in  1  EX instruction is MRET
irq  in  1  level external interrupt
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  zero IF/ID
idex_stall  out  1  ID/EX bubble (control zeroed, data loaded)
idex_flush  out  1  zero ID/EX
exmem_flush  out  1  zero EX/MEM
redirect  out  1  PC takes redirect_pc next edge
redirect_pc  out  32  new PC
csr_we  out  1  write mepc/mcause this cycle
mepc_wdata  out  32  saved PC
mcause_wdata  out  CAUSE_W  2 illegal, 4 misaligned, 11 irq
in_trap  out  1  handler active (interrupts masked)

Behaviour:
- Reset: all outputs 0, state RUN, in_trap=0, saved mepc=0.
- FSM states: RUN, TRAP, MRET_WAIT.
- In RUN, evaluated combinationally each cycle; only the highest-priority event fires:
  1. ex_valid&ex_misalign -> exception. csr_we=1, mepc=ex_pc, cause=4. exmem_flush, idex_flush and ifid_flush asserted. Next state TRAP.
  2. ex_valid&ex_mret -> redirect=1, redirect_pc=saved mepc. idex_flush and ifid_flush asserted. Next state MRET_WAIT.
  3. ex_valid&ex_redirect -> redirect=1, redirect_pc=ex_target. ifid_flush and idex_flush asserted. Stay RUN.
  4. id_valid&id_illegal -> csr_we=1, mepc=id_pc, cause=2. ifid_flush and idex_flush asserted. Next state TRAP.
  5. irq&!in_trap&id_valid -> csr_we=1, mepc=id_pc, cause=11. ifid_flush and idex_flush asserted (EX instruction completes). Next state TRAP.
  6. Load-use: ex_valid&ex_load&ex_rd!=0&((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd)) -> pc_stall, ifid_stall, idex_stall for exactly one cycle. Stay RUN; next cycle ex_load refers to the bubble, so the stall self-clears.
- TRAP, one cycle:
  - redirect=1, redirect_pc=TRAP_VECTOR; ifid_flush and idex_flush asserted.
  - in_trap<=1; saved mepc<=value captured at entry.
  - Next state RUN.
- MRET_WAIT, one cycle: ifid_flush asserted, in_trap<=0, next state RUN.
- mepc/cause are registered internally on csr_we.
- Stall and flush never both assert on the same register in one cycle; flush wins.
- Exception while in_trap: still taken (nested), mepc is overwritten.
- Interrupts are ignored while in_trap=1 or during TRAP/MRET_WAIT.
- rst_n low mid-sequence returns immediately to RUN with all outputs 0.
- x0 never causes a hazard.

Optional Feature:
PIPE_PERF_CNT_EN: when defined, adds outputs stall_cnt[31:0], flush_cnt[31:0] and trap_cnt[15:0].
- stall_cnt increments per load-use stall cycle.
- flush_cnt increments per cycle with any flush.
- trap_cnt increments per TRAP entry.
- All counters saturate at all-ones and reset to 0.
When not defined, these ports and the counter logic are absent.

Decomposition:
Package pipe_ctrl_pkg holds:
- State enum: RUN, TRAP, MRET_WAIT.
- Cause constants: CAUSE_ILLEGAL=2, CAUSE_MISALIGN=4, CAUSE_EXT_IRQ=11.
- Default TRAP_VECTOR.

One sub-module, load_use_detect: purely combinational hazard compare, reused by the forwarding unit.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID -> exactly one cycle pc_stall=ifid_stall=idex_stall=1; no stall for rd=x0.
- Taken branch in EX, target 0x200 -> redirect=1, redirect_pc=0x200, ifid_flush=idex_flush=1 for one cycle, no stall.
- id_illegal at id_pc=0x44 -> csr_we, mepc=0x44, cause=2; next cycle redirect_pc=0x1000, in_trap=1.
- ex_misalign at ex_pc=0x80 with load-use present simultaneously -> exception wins, exmem_flush=1, no stall, cause=4.
- irq held during in_trap=1 -> ignored; after MRET (redirect_pc=saved mepc, in_trap=0), irq taken at the next valid ID with cause=11.
- rst_n asserted during TRAP -> all outputs 0 immediately, RUN after release.
